// File: rtl/room_thermal_model_pkg.sv
// Shared types and Q8.8 constants for the room thermal plant model.
package thermal_pkg;

  typedef logic signed [15:0] q8_8_t;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_WARM_H = 3'd1,
    ST_HEAT   = 3'd2,
    ST_WARM_C = 3'd3,
    ST_COOL   = 3'd4,
    ST_FAULT  = 3'd5
  } plant_state_e;

  localparam q8_8_t Q_0P1   = 16'sh001A;
  localparam q8_8_t Q_0P5   = 16'sh0080;
  localparam q8_8_t Q_M40P0 = 16'shD800;
  localparam q8_8_t Q_85P0  = 16'sh5500;
  localparam q8_8_t Q_20P0  = 16'sh1400;

  // Clamp an 18-bit intermediate into [lo, hi] and return it as Q8.8.
  function automatic q8_8_t sat_q88(input logic signed [17:0] v, input q8_8_t lo, input q8_8_t hi);
    logic signed [17:0] lo_x;
    logic signed [17:0] hi_x;
    lo_x = {{2{lo[15]}}, lo};
    hi_x = {{2{hi[15]}}, hi};
    if (v < lo_x) return lo;
    if (v > hi_x) return hi;
    return v[15:0];
  endfunction

endpackage

// File: rtl/room_thermal_model_if.sv
// Command/observation bundle of the room thermal plant.
interface room_thermal_model_if;
  import thermal_pkg::*;

  logic       heat;
  logic       cool;
  q8_8_t      ambient;
  logic       load_en;
  q8_8_t      load_temp;
  q8_8_t      temp;
  logic       temp_valid;
  logic [2:0] state;
  logic       fault;

  modport master (
    output heat, cool, ambient, load_en, load_temp,
    input  temp, temp_valid, state, fault
  );

  modport slave (
    input  heat, cool, ambient, load_en, load_temp,
    output temp, temp_valid, state, fault
  );
endinterface

// File: rtl/room_thermal_model_prescaler.sv
// Tick generator: counts 0..TICK_DIV-1 and flags the last count of each period.
module thermal_prescaler #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/room_thermal_model.sv
// Room thermal plant: drift toward ambient plus heater/cooler contribution,
// advanced once per tick, with actuator warm-up and conflicting-command fault.
module room_thermal_model
  import thermal_pkg::*;
#(
  parameter int    TICK_DIV     = 10,
  parameter int    WARMUP_TICKS = 2,
  parameter q8_8_t INIT_TEMP    = Q_20P0,
  parameter q8_8_t AMB_RATE     = Q_0P1,
  parameter q8_8_t COND_RATE    = Q_0P5,
  parameter q8_8_t TEMP_MIN     = Q_M40P0,
  parameter q8_8_t TEMP_MAX     = Q_85P0
) (
  input logic                 clk,
  input logic                 reset,
  room_thermal_model_if.slave bus
);
  // The entry tick counts as the first warm-up tick.
  localparam logic [7:0] WARM_LOAD = (WARMUP_TICKS > 0) ? 8'(WARMUP_TICKS - 1) : 8'd0;

  plant_state_e       state_q, state_d;
  q8_8_t              temp_q, temp_d;
  logic [7:0]         warm_q, warm_d;
  logic               valid_q, valid_d;
  logic               fault_q;
  logic               tick;
  logic signed [16:0] diff;
  logic [16:0]        diff_mag, step_mag;
  logic signed [17:0] drift, cond, sum, temp_x, load_x;

  thermal_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (bus.load_en),
    .tick  (tick)
  );

  // Ambient pull is capped at AMB_RATE but never larger than the gap, so it cannot overshoot.
  assign temp_x   = {{2{temp_q[15]}}, temp_q};
  assign diff     = {bus.ambient[15], bus.ambient} - {temp_q[15], temp_q};
  assign diff_mag = diff[16] ? 17'(-diff) : 17'(diff);
  assign step_mag = (diff_mag > {1'b0, AMB_RATE}) ? {1'b0, AMB_RATE} : diff_mag;
  assign drift    = diff[16] ? -$signed({1'b0, step_mag}) : $signed({1'b0, step_mag});
  assign load_x   = {{2{bus.load_temp[15]}}, bus.load_temp};
  assign sum      = temp_x + drift + cond;

  always_comb begin
    cond = '0;
    case (state_q)
      ST_HEAT: cond = {{2{COND_RATE[15]}}, COND_RATE};
      ST_COOL: cond = -{{2{COND_RATE[15]}}, COND_RATE};
      default: cond = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    temp_d  = temp_q;
    valid_d = 1'b0;
    if (bus.load_en) begin
      temp_d = sat_q88(load_x, TEMP_MIN, TEMP_MAX);
    end else if (tick) begin
      temp_d  = sat_q88(sum, TEMP_MIN, TEMP_MAX);
      valid_d = 1'b1;
      if (bus.heat && bus.cool) begin
        state_d = ST_FAULT;
      end else if (state_q == ST_FAULT) begin
        if (!bus.heat && !bus.cool) state_d = ST_OFF;
      end else if (bus.heat) begin
        if (state_q == ST_WARM_H) begin
          if (warm_q <= 8'd1) state_d = ST_HEAT;
          else                warm_d  = warm_q - 8'd1;
        end else if (state_q != ST_HEAT) begin
          state_d = ST_WARM_H;
          warm_d  = WARM_LOAD;
        end
      end else if (bus.cool) begin
        if (state_q == ST_WARM_C) begin
          if (warm_q <= 8'd1) state_d = ST_COOL;
          else                warm_d  = warm_q - 8'd1;
        end else if (state_q != ST_COOL) begin
          state_d = ST_WARM_C;
          warm_d  = WARM_LOAD;
        end
      end else begin
        state_d = ST_OFF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_OFF;
      temp_q  <= INIT_TEMP;
      warm_q  <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      temp_q  <= temp_d;
      warm_q  <= warm_d;
      valid_q <= valid_d;
      fault_q <= (state_d == ST_FAULT);
    end
  end

  assign bus.temp       = temp_q;
  assign bus.temp_valid = valid_q;
  assign bus.state      = state_q;
  assign bus.fault      = fault_q;
endmodule

// File: tb/tb_room_thermal_model.sv
// Scoreboard bench: a plain-arithmetic plant model predicts every tick result,
// a monitor compares whenever the DUT strobes temp_valid.
module tb_room_thermal_model;
  import thermal_pkg::*;

  localparam int TICK_DIV = 10;
  localparam int WARMUP   = 2;
  localparam int AMB      = 'h1A;
  localparam int COND     = 'h80;
  localparam int TMIN     = -'h2800;
  localparam int TMAX     = 'h5500;
  localparam int TINIT    = 'h1400;

  typedef struct {
    int temp;
    int st;
    int flt;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  exp_t exp_q[$];
  int   seen_t[$];
  int   seen_c[$];

  // Model: direction 0 idle, 1 heat, -1 cool, 2 fault; eng = ticks the direction has been held.
  int m_temp = TINIT;
  int m_dir = 0;
  int m_eng = 0;
  int m_cnt = 0;

  room_thermal_model_if bus ();

  room_thermal_model #(
    .TICK_DIV     (TICK_DIV),
    .WARMUP_TICKS (WARMUP),
    .INIT_TEMP    (16'sh1400),
    .AMB_RATE     (16'sh001A),
    .COND_RATE    (16'sh0080),
    .TEMP_MIN     (16'shD800),
    .TEMP_MAX     (16'sh5500)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic int clamp(input int v);
    if (v < TMIN) return TMIN;
    if (v > TMAX) return TMAX;
    return v;
  endfunction

  function automatic int exp_state();
    if (m_dir == 2)  return int'(ST_FAULT);
    if (m_dir == 1)  return (m_eng >= WARMUP) ? int'(ST_HEAT) : int'(ST_WARM_H);
    if (m_dir == -1) return (m_eng >= WARMUP) ? int'(ST_COOL) : int'(ST_WARM_C);
    return int'(ST_OFF);
  endfunction

  function automatic int seen_at(input int i);
    return (i < seen_t.size()) ? seen_t[i] : -99999;
  endfunction

  function automatic int seen_cyc_at(input int i);
    return (i < seen_c.size()) ? seen_c[i] : -99999;
  endfunction

  task automatic model_tick(input int h, input int c, input int amb);
    int d;
    int drift;
    int eff;
    d     = amb - m_temp;
    drift = 0;
    if (d > 0) drift = (d < AMB) ? d : AMB;
    if (d < 0) drift = (-d < AMB) ? d : -AMB;
    eff = 0;
    if (m_dir == 1 && m_eng >= WARMUP)  eff = COND;
    if (m_dir == -1 && m_eng >= WARMUP) eff = -COND;
    m_temp = clamp(m_temp + drift + eff);
    if (h != 0 && c != 0) begin
      m_dir = 2;
    end else if (m_dir == 2) begin
      if (h == 0 && c == 0) m_dir = 0;
    end else if (h != 0) begin
      if (m_dir == 1) m_eng++;
      else begin m_dir = 1; m_eng = 1; end
    end else if (c != 0) begin
      if (m_dir == -1) m_eng++;
      else begin m_dir = -1; m_eng = 1; end
    end else begin
      m_dir = 0;
    end
  endtask

  // Drive one cycle of inputs and advance the model across the edge that consumes them.
  task automatic step(input int h, input int c, input int amb, input int ld, input int ldv, input int rst);
    exp_t e;
    @(negedge clk);
    reset         = (rst != 0);
    bus.heat      = (h != 0);
    bus.cool      = (c != 0);
    bus.ambient   = 16'(amb);
    bus.load_en   = (ld != 0);
    bus.load_temp = 16'(ldv);
    if (rst != 0) begin
      m_temp = TINIT; m_dir = 0; m_eng = 0; m_cnt = 0;
    end else if (ld != 0) begin
      m_temp = clamp(ldv);
      m_cnt  = 0;
    end else if (m_cnt == TICK_DIV - 1) begin
      m_cnt = 0;
      model_tick(h, c, amb);
      e.temp = m_temp;
      e.st   = exp_state();
      e.flt  = (m_dir == 2) ? 1 : 0;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end else begin
      m_cnt++;
    end
  endtask

  task automatic do_reset(input int hold);
    for (int i = 0; i < hold; i++) step(0, 0, TINIT, 0, 0, 1);
    @(posedge clk);
    #1;
    check("rst_temp", int'(bus.temp), TINIT);
    check("rst_state", int'(bus.state), int'(ST_OFF));
    check("rst_fault", int'(bus.fault), 0);
    check("rst_valid", int'(bus.temp_valid), 0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check("missed_valid", cyc, e.cyc);
      end
      if (bus.temp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", int'(bus.temp_valid), 0);
        end else begin
          e = exp_q.pop_front();
          check("temp", int'(bus.temp), e.temp);
          check("state", int'(bus.state), e.st);
          check("fault", int'(bus.fault), e.flt);
          check("valid_cycle", cyc, e.cyc);
          seen_t.push_back(int'(bus.temp));
          seen_c.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    int h_r, c_r, amb_r, ld_r, ldv_r, rs_r, r;
    bus.heat = 1'b0; bus.cool = 1'b0; bus.ambient = '0;
    bus.load_en = 1'b0; bus.load_temp = '0;

    // Idle drift toward warm ambient, first-tick latency after release
    do_reset(2);
    seen_t.delete(); seen_c.delete();
    step(0, 0, 'h1A00, 0, 0, 0);
    rel = cyc;
    repeat (20) step(0, 0, 'h1A00, 0, 0, 0);
    #2;
    check("idle_latency", seen_cyc_at(0) - rel, 10);
    check("idle_tick1", seen_at(0), 'h141A);
    check("idle_tick2", seen_at(1), 'h1434);

    // Cooler warm-up then active cooling
    do_reset(2);
    seen_t.delete(); seen_c.delete();
    step(0, 1, 'h1A00, 1, 'h1A00, 0);
    repeat (41) step(0, 1, 'h1A00, 0, 0, 0);
    #2;
    check("cool_tick1", seen_at(0), 'h1A00);
    check("cool_tick2", seen_at(1), 'h1A00);
    check("cool_tick3", seen_at(2), 'h1980);
    check("cool_tick4", seen_at(3), 'h191A);

    // Conflicting commands: fault, sticky while any command high, clears when both low
    do_reset(2);
    repeat (35) step(1, 0, 'h1300, 0, 0, 0);
    repeat (15) step(1, 1, 'h1300, 0, 0, 0);
    #2;
    check("fault_set", int'(bus.fault), 1);
    check("fault_state", int'(bus.state), int'(ST_FAULT));
    repeat (12) step(1, 0, 'h1300, 0, 0, 0);
    #2;
    check("fault_sticky", int'(bus.fault), 1);
    repeat (12) step(0, 0, 'h1300, 0, 0, 0);
    #2;
    check("fault_clear", int'(bus.fault), 0);
    check("fault_exit_state", int'(bus.state), int'(ST_OFF));

    // Upper saturation
    do_reset(2);
    seen_t.delete(); seen_c.delete();
    step(1, 0, 'h5500, 1, 'h54E6, 0);
    repeat (61) step(1, 0, 'h5500, 0, 0, 0);
    #2;
    check("hi_sat_count", seen_t.size(), 6);
    foreach (seen_t[i]) check("hi_sat_tick", seen_t[i], 'h5500);

    // Lower saturation
    do_reset(2);
    seen_t.delete(); seen_c.delete();
    step(0, 1, -'h2800, 1, -'h27F0, 0);
    repeat (61) step(0, 1, -'h2800, 0, 0, 0);
    #2;
    check("lo_sat_count", seen_t.size(), 6);
    foreach (seen_t[i]) check("lo_sat_tick", seen_t[i], -'h2800);

    // Drift never overshoots a small gap
    do_reset(2);
    seen_t.delete(); seen_c.delete();
    step(0, 0, 'h1A00, 1, 'h1A10, 0);
    repeat (11) step(0, 0, 'h1A00, 0, 0, 0);
    #2;
    check("no_overshoot", seen_at(0), 'h1A00);

    // Out-of-range loads are clamped and produce no strobe
    step(0, 0, 'h1A00, 1, 'h7FFF, 0);
    @(posedge clk); #1;
    check("load_sat_hi", int'(bus.temp), 'h5500);
    check("load_no_valid", int'(bus.temp_valid), 0);
    step(0, 0, 'h1A00, 1, -'h8000, 0);
    @(posedge clk); #1;
    check("load_sat_lo", int'(bus.temp), -'h2800);

    // Reset in the middle of HEAT at prescaler count 5
    do_reset(2);
    for (int i = 0; i < 100 && !(m_dir == 1 && m_eng >= WARMUP && m_cnt == 5); i++)
      step(1, 0, 'h1400, 0, 0, 0);
    #2;
    check("pre_reset_heat", int'(bus.state), int'(ST_HEAT));
    do_reset(1);
    seen_t.delete(); seen_c.delete();
    step(0, 0, 'h1400, 0, 0, 0);
    rel = cyc;
    repeat (10) step(0, 0, 'h1400, 0, 0, 0);
    #2;
    check("post_reset_latency", seen_cyc_at(0) - rel, 10);
    check("post_reset_temp", seen_at(0), 'h1400);

    // Randomized operation
    h_r = 0; c_r = 0; amb_r = 'h1400;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        r   = int'($urandom_range(0, 7));
        h_r = ((r == 3) || (r == 4) || (r == 7)) ? 1 : 0;
        c_r = ((r == 5) || (r == 6) || (r == 7)) ? 1 : 0;
      end
      if ($urandom_range(0, 63) == 0) begin
        if ($urandom_range(0, 1) == 0) amb_r = int'($urandom_range(0, 'h6000)) - 'h3000;
        else                           amb_r = int'($urandom_range(0, 65535)) - 32768;
      end
      ld_r  = ($urandom_range(0, 49) == 0) ? 1 : 0;
      ldv_r = int'($urandom_range(0, 65535)) - 32768;
      rs_r  = ($urandom_range(0, 599) == 0) ? 1 : 0;
      step(h_r, c_r, amb_r, ld_r, ldv_r, rs_r);
    end
    repeat (12) step(0, 0, amb_r, 0, 0, 0);
    #2;
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
